viterbi_acs_sched: RTL and testbench



---
 rtl/viterbi_pkg.sv | 17 +
 rtl/viterbi_acs_sched_if.sv | 34 +++
 rtl/viterbi_branch_cnt.sv | 30 +++
 rtl/viterbi_acs_sched.sv | 167 ++++++++++++++++
 tb/tb_viterbi_acs_sched.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi ACS scheduler: FSM encoding, trellis
// size defaults and the received code-symbol width.
package viterbi_pkg;

  localparam int SYM_W          = 2;
  localparam int DEF_STATE_W    = 2;
  localparam int DEF_NUM_STATES = 1 << DEF_STATE_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BRANCH  = 3'd1,
    ST_COMMIT  = 3'd2,
    ST_TB_WAIT = 3'd3,
    ST_ACK     = 3'd4
  } sched_state_e;

endpackage

// File: rtl/viterbi_acs_sched_if.sv
// Symbol handshake plus BMU/PMU/traceback control bundle of the scheduler.
// master = symbol source / datapath side, slave = the scheduler itself.
interface viterbi_acs_sched_if #(
  parameter int STATE_W = 2,
  parameter int CNT_W   = 5
);

  logic                          seq_rdy;
  logic [viterbi_pkg::SYM_W-1:0] rx;
  logic                          tb_done;
  logic [viterbi_pkg::SYM_W-1:0] rx_q;
  logic [STATE_W-1:0]            cur_state;
  logic                          input_bit;
  logic                          branch_vld;
  logic                          pm_commit;
  logic                          tb_start;
  logic                          data_ack;
  logic [CNT_W-1:0]              sym_cnt;
  logic                          busy;
  logic                          tb_err;

  modport master (
    output seq_rdy, rx, tb_done,
    input  rx_q, cur_state, input_bit, branch_vld, pm_commit, tb_start,
           data_ack, sym_cnt, busy, tb_err
  );

  modport slave (
    input  seq_rdy, rx, tb_done,
    output rx_q, cur_state, input_bit, branch_vld, pm_commit, tb_start,
           data_ack, sym_cnt, busy, tb_err
  );

endinterface

// File: rtl/viterbi_branch_cnt.sv
// Combined {cur_state, input_bit} branch counter; input_bit is the LSB so it
// toggles fastest. o_last flags the final (NUM_STATES-1, 1) branch.
module viterbi_branch_cnt #(
  parameter int STATE_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_inc,
  output logic [STATE_W-1:0] o_cur_state,
  output logic               o_input_bit,
  output logic               o_last
);

  logic [STATE_W:0] r_cnt;

  // Incrementing past the last branch wraps naturally back to (0, 0).
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + (STATE_W + 1)'(1);
    end
  end

  assign o_cur_state = r_cnt[STATE_W:1];
  assign o_input_bit = r_cnt[0];
  assign o_last      = &r_cnt;

endmodule

// File: rtl/viterbi_acs_sched.sv
// Viterbi ACS sequencing controller: walks all trellis branches per symbol,
// commits path metrics, and runs traceback at frame end. Optional traceback
// watchdog enabled by defining SCHED_TB_TIMEOUT_EN.
module viterbi_acs_sched
  import viterbi_pkg::*;
#(
  parameter int STATE_W    = DEF_STATE_W,
  parameter int FRAME_LEN  = 16,
  parameter int CNT_W      = 5,
  parameter int TB_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  viterbi_acs_sched_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(FRAME_LEN - 1);

  generate
    if (((1 << CNT_W) < FRAME_LEN) || (FRAME_LEN < 2) || (TB_TIMEOUT < 1)) begin : g_bad_cfg
      $error("viterbi_acs_sched: invalid FRAME_LEN/CNT_W/TB_TIMEOUT combination");
    end
  endgenerate

  sched_state_e r_state;
  sched_state_e w_state_next;

  logic               w_cnt_clr;
  logic               w_cnt_inc;
  logic               w_last;
  logic               w_frame_end;
  logic               w_tb_expired;
  logic [STATE_W-1:0] w_cur_state;
  logic               w_input_bit;

  logic [SYM_W-1:0]   r_rx_q;
  logic [CNT_W-1:0]   r_sym_cnt;
  logic               r_branch_vld;
  logic               r_pm_commit;
  logic               r_tb_start;
  logic               r_data_ack;
  logic               r_busy;

  assign w_frame_end = (r_sym_cnt == LAST_SYM);

  viterbi_branch_cnt #(
    .STATE_W (STATE_W)
  ) u_branch_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_cnt_clr),
    .i_inc       (w_cnt_inc),
    .o_cur_state (w_cur_state),
    .o_input_bit (w_input_bit),
    .o_last      (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.seq_rdy) begin
          w_state_next = ST_BRANCH;
          w_cnt_clr    = 1'b1;
        end
      end
      ST_BRANCH: begin
        w_cnt_inc = 1'b1;
        if (w_last) begin
          w_state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_state_next = w_frame_end ? ST_TB_WAIT : ST_ACK;
      end
      ST_TB_WAIT: begin
        if (bus.tb_done || w_tb_expired) begin
          w_state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Control outputs are registered from the next state so each one lines up
  // with the cycle the FSM actually spends in the corresponding state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_q       <= '0;
      r_sym_cnt    <= '0;
      r_branch_vld <= 1'b0;
      r_pm_commit  <= 1'b0;
      r_tb_start   <= 1'b0;
      r_data_ack   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && bus.seq_rdy) begin
        r_rx_q <= bus.rx;
      end
      if (r_state == ST_COMMIT) begin
        r_sym_cnt <= w_frame_end ? '0 : r_sym_cnt + CNT_W'(1);
      end
      r_branch_vld <= (w_state_next == ST_BRANCH);
      r_pm_commit  <= (w_state_next == ST_COMMIT);
      r_tb_start   <= (w_state_next == ST_COMMIT) && w_frame_end;
      r_data_ack   <= (w_state_next == ST_ACK);
      r_busy       <= (w_state_next != ST_IDLE);
    end
  end

`ifdef SCHED_TB_TIMEOUT_EN
  localparam int WD_W = $clog2(TB_TIMEOUT + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_tb_err;

  // Counter sits at zero outside TB_WAIT so each frame starts a fresh window.
  assign w_tb_expired = (r_wd_cnt == WD_W'(TB_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
      r_tb_err <= 1'b0;
    end else begin
      if (r_state == ST_TB_WAIT) begin
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
        if (w_tb_expired && !bus.tb_done) begin
          r_tb_err <= 1'b1;
        end
      end else begin
        r_wd_cnt <= '0;
      end
    end
  end

  assign bus.tb_err = r_tb_err;
`else
  assign w_tb_expired = 1'b0;
  assign bus.tb_err   = 1'b0;
`endif

  assign bus.rx_q       = r_rx_q;
  assign bus.cur_state  = w_cur_state;
  assign bus.input_bit  = w_input_bit;
  assign bus.branch_vld = r_branch_vld;
  assign bus.pm_commit  = r_pm_commit;
  assign bus.tb_start   = r_tb_start;
  assign bus.data_ack   = r_data_ack;
  assign bus.sym_cnt    = r_sym_cnt;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_viterbi_acs_sched.sv
// Self-checking bench for viterbi_acs_sched: random symbols, frame ends,
// stray tb_done, mid-branch reset and (with SCHED_TB_TIMEOUT_EN) the watchdog.
module tb_viterbi_acs_sched;

  localparam int STATE_W    = 2;
  localparam int NUM_ST     = 1 << STATE_W;
  localparam int FRAME_LEN  = 16;
  localparam int CNT_W      = 5;
  localparam int TB_TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the outputs must show between symbols.
  int         m_sym_cnt = 0;
  logic [1:0] m_rx_q    = 2'b00;
  bit         m_tb_err  = 1'b0;

  viterbi_acs_sched_if #(.STATE_W(STATE_W), .CNT_W(CNT_W)) bus ();

  viterbi_acs_sched #(
    .STATE_W    (STATE_W),
    .FRAME_LEN  (FRAME_LEN),
    .CNT_W      (CNT_W),
    .TB_TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tb_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_vals();
    tb_check("rst_rx_q",       32'(bus.rx_q),       32'd0);
    tb_check("rst_cur_state",  32'(bus.cur_state),  32'd0);
    tb_check("rst_input_bit",  32'(bus.input_bit),  32'd0);
    tb_check("rst_branch_vld", 32'(bus.branch_vld), 32'd0);
    tb_check("rst_pm_commit",  32'(bus.pm_commit),  32'd0);
    tb_check("rst_tb_start",   32'(bus.tb_start),   32'd0);
    tb_check("rst_data_ack",   32'(bus.data_ack),   32'd0);
    tb_check("rst_sym_cnt",    32'(bus.sym_cnt),    32'd0);
    tb_check("rst_busy",       32'(bus.busy),       32'd0);
    tb_check("rst_tb_err",     32'(bus.tb_err),     32'd0);
  endtask

  task automatic check_idle();
    tb_check("idle_busy",       32'(bus.busy),       32'd0);
    tb_check("idle_data_ack",   32'(bus.data_ack),   32'd0);
    tb_check("idle_branch_vld", 32'(bus.branch_vld), 32'd0);
    tb_check("idle_pm_commit",  32'(bus.pm_commit),  32'd0);
    tb_check("idle_sym_cnt",    32'(bus.sym_cnt),    32'(m_sym_cnt));
    tb_check("idle_rx_q",       32'(bus.rx_q),       32'(m_rx_q));
    tb_check("idle_tb_err",     32'(bus.tb_err),     32'(m_tb_err));
  endtask

  // Starts at the negedge of an IDLE cycle, ends at the negedge of the IDLE
  // cycle following ACK. tb_lat = cycles from entering TB_WAIT to tb_done
  // (0 = never). abort_at = branch index at which rst is applied (-1 = none).
  task automatic do_symbol(input logic [1:0] sym, input bit hold_rdy,
                           input int tb_lat, input int abort_at);
    bit fe;
    int wait_n;
    bus.seq_rdy = 1'b1;
    bus.rx      = sym;
    bus.tb_done = 1'b0;
    @(negedge clk);
    m_rx_q = sym;
    for (int b = 0; b < 2 * NUM_ST; b++) begin
      tb_check("br_vld",       32'(bus.branch_vld), 32'd1);
      tb_check("br_cur_state", 32'(bus.cur_state),  32'(b / 2));
      tb_check("br_input_bit", 32'(bus.input_bit),  32'(b % 2));
      tb_check("br_rx_q",      32'(bus.rx_q),       32'(m_rx_q));
      tb_check("br_pm_commit", 32'(bus.pm_commit),  32'd0);
      tb_check("br_tb_start",  32'(bus.tb_start),   32'd0);
      tb_check("br_data_ack",  32'(bus.data_ack),   32'd0);
      tb_check("br_busy",      32'(bus.busy),       32'd1);
      if (b == abort_at) begin
        rst         = 1'b1;
        bus.seq_rdy = 1'b0;
        bus.tb_done = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        m_rx_q    = 2'b00;
        m_sym_cnt = 0;
        m_tb_err  = 1'b0;
        check_reset_vals();
        for (int k = 0; k < 2 * NUM_ST + 4; k++) begin
          @(negedge clk);
          tb_check("abort_pm_commit", 32'(bus.pm_commit), 32'd0);
          tb_check("abort_data_ack",  32'(bus.data_ack),  32'd0);
          tb_check("abort_busy",      32'(bus.busy),      32'd0);
        end
        $display("txn abort sym=%0d at branch %0d", sym, b);
        return;
      end
      bus.rx      = 2'($urandom);
      bus.tb_done = 1'($urandom);
      @(negedge clk);
    end
    bus.tb_done = 1'b0;
    fe        = (m_sym_cnt == FRAME_LEN - 1);
    m_sym_cnt = (m_sym_cnt + 1) % FRAME_LEN;
    tb_check("cm_pm_commit",  32'(bus.pm_commit),  32'd1);
    tb_check("cm_tb_start",   32'(bus.tb_start),   32'(fe));
    tb_check("cm_branch_vld", 32'(bus.branch_vld), 32'd0);
    tb_check("cm_cur_state",  32'(bus.cur_state),  32'd0);
    tb_check("cm_input_bit",  32'(bus.input_bit),  32'd0);
    tb_check("cm_data_ack",   32'(bus.data_ack),   32'd0);
    @(negedge clk);
    if (fe) begin
      wait_n = (tb_lat > 0) ? tb_lat : TB_TIMEOUT;
      for (int w = 0; w < wait_n; w++) begin
        tb_check("tw_data_ack",  32'(bus.data_ack),  32'd0);
        tb_check("tw_pm_commit", 32'(bus.pm_commit), 32'd0);
        tb_check("tw_tb_start",  32'(bus.tb_start),  32'd0);
        tb_check("tw_sym_cnt",   32'(bus.sym_cnt),   32'd0);
        tb_check("tw_busy",      32'(bus.busy),      32'd1);
        bus.tb_done = (tb_lat > 0) && (w == wait_n - 1);
        @(negedge clk);
      end
      bus.tb_done = 1'b0;
      if (tb_lat == 0) m_tb_err = 1'b1;
    end
    tb_check("ack_data_ack",  32'(bus.data_ack),  32'd1);
    tb_check("ack_pm_commit", 32'(bus.pm_commit), 32'd0);
    tb_check("ack_sym_cnt",   32'(bus.sym_cnt),   32'(m_sym_cnt));
    tb_check("ack_rx_q",      32'(bus.rx_q),      32'(m_rx_q));
    tb_check("ack_tb_err",    32'(bus.tb_err),    32'(m_tb_err));
    tb_check("ack_busy",      32'(bus.busy),      32'd1);
    if (!hold_rdy) bus.seq_rdy = 1'b0;
    bus.rx = 2'($urandom);
    @(negedge clk);
    check_idle();
    $display("txn sym=%0d frame_end=%0d tb_lat=%0d sym_cnt=%0d tb_err=%0d",
             sym, fe, tb_lat, m_sym_cnt, m_tb_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit hold;
    int gap;
    bus.seq_rdy = 1'b0;
    bus.rx      = 2'b00;
    bus.tb_done = 1'b0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    check_idle();

    do_symbol(2'b10, 1'b0, 1, -1);

    // Stray tb_done while idle must be ignored.
    repeat (3) begin
      bus.tb_done = 1'b1;
      @(negedge clk);
      check_idle();
    end
    bus.tb_done = 1'b0;

    for (int i = 0; i < 22; i++) begin
      hold = 1'($urandom_range(0, 1));
      do_symbol(2'($urandom), hold, int'($urandom_range(1, 8)), -1);
      if (!hold) begin
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          bus.tb_done = 1'($urandom);
          @(negedge clk);
          check_idle();
        end
        bus.tb_done = 1'b0;
      end
    end

    do_symbol(2'b01, 1'b0, 1, 3);

    for (int i = 0; i < 34; i++) begin
      int lat;
      lat = int'($urandom_range(1, 8));
`ifdef SCHED_TB_TIMEOUT_EN
      if (i == 15) lat = 0;
`endif
      do_symbol(2'($urandom), (i % 3) != 0, lat, -1);
    end

    bus.seq_rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
